// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory sequencer:
// access-size codes, FSM state encoding and alignment helpers.
package mem_access_ctrl_pkg;

    localparam logic [2:0] SlWord      = 3'd0;
    localparam logic [2:0] SlHalf      = 3'd1;
    localparam logic [2:0] SlByte      = 3'd2;
    localparam logic [2:0] SlHalfu     = 3'd3;
    localparam logic [2:0] SlByteu     = 3'd4;
    localparam logic [2:0] SlWordleft  = 3'd5;
    localparam logic [2:0] SlWordright = 3'd6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic is_misaligned(input logic [2:0] code, input logic [1:0] addr);
        logic mis;
        mis = 1'b0;
        case (code)
            SlWord:          mis = (addr != 2'b00);
            SlHalf, SlHalfu: mis = addr[0];
            default:         mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Stores only exist in word, half and byte sizes.
    function automatic logic is_store_code(input logic [2:0] code);
        return (code == SlWord) || (code == SlHalf) || (code == SlByte);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_store_lane_gen.sv
// Byte-enable and lane-replicated write data for the data-memory bus.
module mem_access_ctrl_store_lane_gen
    import mem_access_ctrl_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  slctrl_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o
);

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        if (we_i) begin
            case (slctrl_i)
                SlHalf: begin
                    be_o    = 4'b0011 << {addr_i[1], 1'b0};
                    wdata_o = {2{wdata_i[15:0]}};
                end
                SlByte: begin
                    be_o    = 4'b0001 << addr_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: alignment checks, registered bus
// request with variable-latency ack, pipeline stall and bus timeout.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_slctrl_i,
    output logic        stall_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_memd_o,
    output logic [1:0]  rsp_bytesel_o,
    output logic        exc_adel_o,
    output logic        exc_ades_o,
    output logic        bus_err_o
);

    state_e            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_memd_q, rsp_memd_d;
    logic [1:0]        rsp_bytesel_q, rsp_bytesel_d;
    logic              bus_err_q, bus_err_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic        misaligned;
    logic        illegal;
    logic        in_idle;
    logic        accept;

    mem_access_ctrl_store_lane_gen u_lane_gen (
        .we_i     (req_we_i),
        .slctrl_i (req_slctrl_i),
        .addr_i   (req_addr_i[1:0]),
        .wdata_i  (req_wdata_i),
        .be_o     (lane_be),
        .wdata_o  (lane_wdata)
    );

    always_comb begin
        misaligned = is_misaligned(req_slctrl_i, req_addr_i[1:0]);
        illegal    = req_we_i & ~is_store_code(req_slctrl_i);
        in_idle    = (state_q == StIdle);
        exc_adel_o = in_idle & req_valid_i & misaligned & ~req_we_i;
        exc_ades_o = in_idle & req_valid_i & req_we_i & (misaligned | illegal);
        accept     = in_idle & req_valid_i & ~misaligned & ~illegal;
        stall_o    = accept | (state_q == StBusy);
    end

    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_memd_d    = rsp_memd_q;
        rsp_bytesel_d = rsp_bytesel_q;
        bus_err_d     = bus_err_q;
        cnt_d         = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    bus_req_d     = 1'b1;
                    bus_we_d      = req_we_i;
                    bus_addr_d    = {req_addr_i[31:2], 2'b00};
                    bus_be_d      = lane_be;
                    bus_wdata_d   = lane_wdata;
                    rsp_bytesel_d = req_addr_i[1:0];
                    cnt_d         = '0;
                    state_d       = StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_q + TO_W'(1);
                // An ack in the final allowed cycle still wins over the timeout.
                if (bus_ack_i) begin
                    rsp_memd_d  = bus_we_q ? 32'h0 : bus_rdata_i;
                    bus_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = StDone;
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    rsp_memd_d  = 32'h0;
                    bus_req_d   = 1'b0;
                    bus_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                rsp_valid_d = 1'b0;
                bus_err_d   = 1'b0;
                cnt_d       = '0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 32'h0;
            bus_be_q      <= 4'h0;
            bus_wdata_q   <= 32'h0;
            rsp_valid_q   <= 1'b0;
            rsp_memd_q    <= 32'h0;
            rsp_bytesel_q <= 2'b00;
            bus_err_q     <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_memd_q    <= rsp_memd_d;
            rsp_bytesel_q <= rsp_bytesel_d;
            bus_err_q     <= bus_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus_req_o     = bus_req_q;
    assign bus_we_o      = bus_we_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_be_o      = bus_be_q;
    assign bus_wdata_o   = bus_wdata_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_memd_o    = rsp_memd_q;
    assign rsp_bytesel_o = rsp_bytesel_q;
    assign bus_err_o     = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl, built with TIMEOUT=4.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk;
    logic        reset_i;
    logic        req_valid_i;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [2:0]  req_slctrl_i;
    logic        stall_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_memd_o;
    logic [1:0]  rsp_bytesel_o;
    logic        exc_adel_o;
    logic        exc_ades_o;
    logic        bus_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_ctrl #(
        .TIMEOUT (4),
        .TO_W    (8)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .req_valid_i   (req_valid_i),
        .req_we_i      (req_we_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .req_slctrl_i  (req_slctrl_i),
        .stall_o       (stall_o),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_be_o      (bus_be_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_ack_i     (bus_ack_i),
        .bus_rdata_i   (bus_rdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_memd_o    (rsp_memd_o),
        .rsp_bytesel_o (rsp_bytesel_o),
        .exc_adel_o    (exc_adel_o),
        .exc_ades_o    (exc_ades_o),
        .bus_err_o     (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  code;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] data;
    } st_vec_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  code;
        logic [31:0] addr;
        logic        adel;
        logic        ades;
    } exc_vec_t;

    st_vec_t st_tab [5] = '{
        '{SlByte, 32'h0000_2003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5},
        '{SlByte, 32'h0000_2001, 32'h1122_333C, 4'b0010, 32'h3C3C_3C3C},
        '{SlHalf, 32'h0000_2002, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF},
        '{SlHalf, 32'h0000_2000, 32'hCAFE_1234, 4'b0011, 32'h1234_1234},
        '{SlWord, 32'h0000_2008, 32'h0123_4567, 4'b1111, 32'h0123_4567}
    };

    exc_vec_t exc_tab [7] = '{
        '{1'b0, SlHalf,     32'h0000_1001, 1'b1, 1'b0},
        '{1'b0, SlWord,     32'h0000_1002, 1'b1, 1'b0},
        '{1'b0, SlHalfu,    32'h0000_1003, 1'b1, 1'b0},
        '{1'b1, SlWord,     32'h0000_1002, 1'b0, 1'b1},
        '{1'b1, SlHalf,     32'h0000_1001, 1'b0, 1'b1},
        '{1'b1, SlByteu,    32'h0000_1000, 1'b0, 1'b1},
        '{1'b1, SlWordleft, 32'h0000_1003, 1'b0, 1'b1}
    };

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic we, input logic [2:0] code, input logic [31:0] addr,
                           input logic [31:0] wdata);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_slctrl_i = code;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus_req_o !== 1'b0 || rsp_valid_o !== 1'b0 || bus_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: req=%b rsp_valid=%b err=%b, want 0 0 0",
                     bus_req_o, rsp_valid_o, bus_err_o);
        end
        n_checks++;
        if (bus_addr_o !== 32'h0 || bus_be_o !== 4'h0 || bus_wdata_o !== 32'h0 ||
            rsp_memd_o !== 32'h0 || rsp_bytesel_o !== 2'b00 || bus_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: addr=%h be=%b wd=%h memd=%h bsel=%b we=%b, want all 0",
                     bus_addr_o, bus_be_o, bus_wdata_o, rsp_memd_o, rsp_bytesel_o, bus_we_o);
        end
        n_checks++;
        if (stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: got %b want 0", stall_o);
        end
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_load_zero_wait;
        set_req(1'b0, SlWord, 32'h0000_1004, 32'h0);
        #1;
        n_checks++;
        if (stall_o !== 1'b1 || bus_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_accept: stall=%b req=%b, want 1 0", stall_o, bus_req_o);
        end
        tick();
        n_checks++;
        if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h0000_1004 || bus_be_o !== 4'b1111 ||
            bus_we_o !== 1'b0 || stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL lw_busy: req=%b addr=%h be=%b we=%b stall=%b, want 1 00001004 1111 0 1",
                     bus_req_o, bus_addr_o, bus_be_o, bus_we_o, stall_o);
        end
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hDEAD_BEEF;
        tick();
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
        req_valid_i = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid_o !== 1'b1 || stall_o !== 1'b0 || rsp_memd_o !== 32'hDEAD_BEEF ||
            rsp_bytesel_o !== 2'b00 || bus_req_o !== 1'b0 || bus_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_done: rv=%b stall=%b memd=%h bsel=%b req=%b err=%b, want 1 0 deadbeef 0 0 0",
                     rsp_valid_o, stall_o, rsp_memd_o, rsp_bytesel_o, bus_req_o, bus_err_o);
        end
        tick();
        n_checks++;
        if (rsp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_pulse_width: rsp_valid=%b want 0", rsp_valid_o);
        end
    endtask

    task automatic test_timeout;
        set_req(1'b0, SlWord, 32'h0000_3000, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if (bus_req_o !== 1'b1 || rsp_valid_o !== 1'b0 || bus_err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL to_wait%0d: req=%b rv=%b err=%b, want 1 0 0",
                         i, bus_req_o, rsp_valid_o, bus_err_o);
            end
        end
        tick();
        req_valid_i = 1'b0;
        n_checks++;
        if (rsp_valid_o !== 1'b1 || bus_err_o !== 1'b1 || rsp_memd_o !== 32'h0 ||
            bus_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL to_err: rv=%b err=%b memd=%h req=%b, want 1 1 0 0",
                     rsp_valid_o, bus_err_o, rsp_memd_o, bus_req_o);
        end
        tick();
        n_checks++;
        if (rsp_valid_o !== 1'b0 || bus_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL to_clear: rv=%b err=%b, want 0 0", rsp_valid_o, bus_err_o);
        end
    endtask

    task automatic test_store_lanes;
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, st_tab[i].code, st_tab[i].addr, st_tab[i].wdata);
            #1;
            n_checks++;
            if (stall_o !== 1'b1 || exc_ades_o !== 1'b0) begin
                n_fail++;
                $display("FAIL st%0d_accept: stall=%b ades=%b, want 1 0", i, stall_o, exc_ades_o);
            end
            tick();
            n_checks++;
            if (bus_req_o !== 1'b1 || bus_we_o !== 1'b1 || bus_be_o !== st_tab[i].be ||
                bus_wdata_o !== st_tab[i].data ||
                bus_addr_o !== {st_tab[i].addr[31:2], 2'b00}) begin
                n_fail++;
                $display("FAIL st%0d_bus: req=%b we=%b be=%b wd=%h addr=%h, want 1 1 %b %h %h",
                         i, bus_req_o, bus_we_o, bus_be_o, bus_wdata_o, bus_addr_o,
                         st_tab[i].be, st_tab[i].data, {st_tab[i].addr[31:2], 2'b00});
            end
            bus_ack_i   = 1'b1;
            bus_rdata_i = 32'hFFFF_FFFF;
            tick();
            bus_ack_i   = 1'b0;
            req_valid_i = 1'b0;
            n_checks++;
            if (rsp_valid_o !== 1'b1 || rsp_memd_o !== 32'h0 ||
                rsp_bytesel_o !== st_tab[i].addr[1:0]) begin
                n_fail++;
                $display("FAIL st%0d_done: rv=%b memd=%h bsel=%b, want 1 0 %b",
                         i, rsp_valid_o, rsp_memd_o, rsp_bytesel_o, st_tab[i].addr[1:0]);
            end
            tick();
        end
    endtask

    task automatic test_exceptions;
        for (int i = 0; i < 7; i++) begin
            set_req(exc_tab[i].we, exc_tab[i].code, exc_tab[i].addr, 32'h5555_AAAA);
            #1;
            n_checks++;
            if (exc_adel_o !== exc_tab[i].adel || exc_ades_o !== exc_tab[i].ades ||
                stall_o !== 1'b0) begin
                n_fail++;
                $display("FAIL exc%0d: adel=%b ades=%b stall=%b, want %b %b 0",
                         i, exc_adel_o, exc_ades_o, stall_o, exc_tab[i].adel, exc_tab[i].ades);
            end
            tick();
            n_checks++;
            if (bus_req_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL exc%0d_nobus: req=%b rv=%b, want 0 0", i, bus_req_o, rsp_valid_o);
            end
        end
        req_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_busy;
        set_req(1'b0, SlWord, 32'h0000_4000, 32'h0);
        tick();
        tick();
        reset_i = 1'b1;
        tick();
        reset_i     = 1'b0;
        req_valid_i = 1'b0;
        #1;
        n_checks++;
        if (bus_req_o !== 1'b0 || stall_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy: req=%b stall=%b rv=%b, want 0 0 0",
                     bus_req_o, stall_o, rsp_valid_o);
        end
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h1111_1111;
        tick();
        bus_ack_i = 1'b0;
        n_checks++;
        if (rsp_valid_o !== 1'b0 || rsp_memd_o !== 32'h0 || bus_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL late_ack: rv=%b memd=%h req=%b, want 0 0 0",
                     rsp_valid_o, rsp_memd_o, bus_req_o);
        end
        tick();
        n_checks++;
        if (rsp_valid_o !== 1'b0 || stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL late_ack2: rv=%b stall=%b, want 0 0", rsp_valid_o, stall_o);
        end
    endtask

    task automatic test_back_to_back;
        int          waits;
        int          pulses;
        int          first_cyc;
        int          second_cyc;
        logic [31:0] exp_memd;
        waits      = 0;
        pulses     = 0;
        first_cyc  = -1;
        second_cyc = -1;
        exp_memd   = 32'hAAAA_0001;
        set_req(1'b0, SlWord, 32'h0000_5000, 32'h0);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick();
            // Ack on the 4th cycle bus_req is seen high.
            if (bus_req_o === 1'b1) waits++;
            else waits = 0;
            bus_ack_i   = (waits == 4);
            bus_rdata_i = (pulses == 0) ? 32'hAAAA_0001 : 32'hBBBB_0002;
            if (rsp_valid_o === 1'b1) begin
                n_checks++;
                if (rsp_memd_o !== exp_memd) begin
                    n_fail++;
                    $display("FAIL b2b_memd%0d: got %h want %h", pulses, rsp_memd_o, exp_memd);
                end
                pulses++;
                if (pulses == 1) begin
                    first_cyc = cyc;
                    exp_memd  = 32'hBBBB_0002;
                    set_req(1'b0, SlWord, 32'h0000_5004, 32'h0);
                end else begin
                    second_cyc  = cyc;
                    req_valid_i = 1'b0;
                end
            end
        end
        bus_ack_i = 1'b0;
        n_checks++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d pulses want 2", pulses);
        end
        n_checks++;
        if (second_cyc - first_cyc != 6 || first_cyc != 5) begin
            n_fail++;
            $display("FAIL b2b_spacing: pulses at %0d and %0d, want 5 and 11",
                     first_cyc, second_cyc);
        end
    endtask

    initial begin
        reset_i      = 1'b1;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_addr_i   = 32'h0;
        req_wdata_i  = 32'h0;
        req_slctrl_i = SlWord;
        bus_ack_i    = 1'b0;
        bus_rdata_i  = 32'h0;

        test_reset();
        test_load_zero_wait();
        test_timeout();
        test_store_lanes();
        test_exceptions();
        test_reset_mid_busy();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the MEM-stage data-memory port. Accepts one load/store per instruction from the pipeline, checks alignment, drives a word-wide request/acknowledge bus with variable latency and stalls the pipeline until the bus acknowledges. Returns the raw read word plus byte offset to the load-extraction logic, which performs the sign/zero extension and lwl/lwr merge. Reports address exceptions and bus timeouts to the CP0 exception logic.

## Interface
- TIMEOUT, 255: BUSY cycles without `bus_ack` before a bus error is declared (1..2^TO_W-1).
- TO_W, 8: width of the timeout counter.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  MEM stage holds a memory instruction (held stable while `stall`)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store source (rt)
- req_slctrl  in  3  access-size code (shared load/store encoding)
- stall  out  1  freeze IF..MEM this cycle
- bus_req, bus_we  out  1  registered bus request / write
- bus_addr  out  32  {req_addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  one-cycle completion pulse
- bus_rdata  in  32  read word, valid with `bus_ack`
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_memd  out  32  latched read word
- rsp_bytesel  out  2  latched req_addr[1:0]
- exc_adel, exc_ades, bus_err  out  1  exception flags

## Operation
- States IDLE, BUSY, DONE. Reset: state IDLE; every registered output (bus_req, bus_we, bus_addr, bus_be, bus_wdata, rsp_valid, rsp_memd, rsp_bytesel, bus_err, counter) is 0.
- Misaligned: word code with addr[1:0]≠0; half/halfu with addr[0]≠0. Byte, wordleft and wordright are never misaligned.
- Illegal: req_we with a code other than word/half/byte raises exc_ades.
- exc_adel / exc_ades are combinational in IDLE only: req_valid & misaligned & (!req_we / req_we). No bus activity, no stall.
- IDLE, req_valid, no exception: latch address, enables, data and bytesel. Set bus_req=1 and go to BUSY.
- Enables and data:
  - Loads: be=1111.
  - sw: be=1111, data=wdata.
  - sh: be=0011<<{addr[1],0}, data={2{wdata[15:0]}}.
  - sb: be=0001<<addr[1:0], data={4{wdata[7:0]}}.
- BUSY:
  - Counter increments each cycle.
  - On bus_ack: latch rsp_memd=bus_rdata (0 for stores), clear bus_req, go to DONE.
  - If the counter reaches TIMEOUT with no ack: clear bus_req, set rsp_memd=0 and bus_err=1, go to DONE.
  - bus_req/addr/be/wdata stay constant throughout BUSY.
- DONE: rsp_valid=1 for one cycle, bus_err held for the same cycle. Counter cleared. Go to IDLE.
- stall = (IDLE & req_valid & legal) | BUSY. stall is 0 in DONE, so the instruction advances there.
- bus_ack outside BUSY is ignored.
- reset in any state: IDLE at the next edge, bus_req dropped; an outstanding transaction is abandoned.

## Timing
- Cycle 0, IDLE: request accepted, stall=1. Cycle 1: BUSY, bus_req=1.
- ack sampled in cycle k≥1 → DONE in cycle k+1 with rsp_valid=1, stall=0.
- Minimum occupancy 3 cycles: zero-wait ack in cycle 1, DONE in cycle 2.
- Back-to-back accesses: the next instruction is sampled in IDLE at cycle k+2.
- Timeout: bus_err pulses in cycle TIMEOUT+1 after the BUSY entry.

## Structure
- Shared header define.v holds slword, slhalf, slbyte, slhalfu, slbyteu, slwordleft, slwordright (3-bit) and the state encodings.
- One natural sub-module, store_lane_gen: combinational be/wdata generation from code, addr[1:0] and wdata.

## Test plan
- lw 0x0000_1004, ack in the cycle after bus_req with rdata 0xDEADBEEF → stall for 2 cycles; rsp_valid with rsp_memd=0xDEADBEEF, bytesel=0.
- sb addr 0x...03, wdata 0x000000A5 → bus_be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x...00.
- lh addr 0x...01 → exc_adel=1, stall=0, bus_req never asserted. sw addr 0x...02 → exc_ades=1.
- Load with bus_ack withheld and TIMEOUT=4 → bus_req stays high 4 cycles, then bus_err and rsp_valid pulse together, rsp_memd=0.
- reset asserted in cycle 2 of BUSY → next cycle IDLE, bus_req=0, stall=0; a late bus_ack is ignored.
- Two consecutive loads, each with 3-cycle ack latency → exactly two rsp_valid pulses, 6 cycles apart.
